// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight at a time: IDLE (grant) -> EXEC (ALU driven) -> RESP (broadcast).
module alu_arbiter #(
  parameter int W       = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,

  input  logic         i_req0_vld,
  input  logic [W-1:0] i_req0_src0,
  input  logic [W-1:0] i_req0_src1,
  input  logic [3:0]   i_req0_op,
  input  logic [3:0]   i_req0_shamt,
  output logic         o_req0_rdy,

  input  logic         i_req1_vld,
  input  logic [W-1:0] i_req1_src0,
  input  logic [W-1:0] i_req1_src1,
  input  logic [3:0]   i_req1_op,
  input  logic [3:0]   i_req1_shamt,
  output logic         o_req1_rdy,

  output logic [W-1:0] o_alu_src0,
  output logic [W-1:0] o_alu_src1,
  output logic [3:0]   o_alu_op,
  output logic [3:0]   o_alu_shamt,
  input  logic [W-1:0] i_alu_dst,
  input  logic         i_alu_ov,
  input  logic         i_alu_zr,
  input  logic         i_alu_neg,

  output logic         o_rsp_vld,
  output logic         o_rsp_id,
  output logic [W-1:0] o_rsp_dst,
  output logic [2:0]   o_flags0,
  output logic [2:0]   o_flags1,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_ptr;
  logic [W-1:0]   r_src0;
  logic [W-1:0]   r_src1;
  logic [3:0]     r_op;
  logic [3:0]     r_shamt;
  logic           r_id;
  logic [W-1:0]   r_rsp_dst;

  logic [1:0]     w_vld;
  logic [W-1:0]   w_src0  [2];
  logic [W-1:0]   w_src1  [2];
  logic [3:0]     w_op    [2];
  logic [3:0]     w_shamt [2];
  logic [2:0]     w_flags [2];
  logic           w_any;
  logic           w_winner;
  logic           w_xfer;
  logic           w_wr_all;
  logic           w_wr_zr;

  assign w_vld      = {i_req1_vld, i_req0_vld};
  assign w_src0[0]  = i_req0_src0;
  assign w_src0[1]  = i_req1_src0;
  assign w_src1[0]  = i_req0_src1;
  assign w_src1[1]  = i_req1_src1;
  assign w_op[0]    = i_req0_op;
  assign w_op[1]    = i_req1_op;
  assign w_shamt[0] = i_req0_shamt;
  assign w_shamt[1] = i_req1_shamt;

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    w_any    = |w_vld;
    w_winner = (&w_vld) ? r_ptr : w_vld[1];
    w_xfer   = (r_state == S_IDLE) && w_any;
  end

  assign o_req0_rdy = w_xfer && !w_winner;
  assign o_req1_rdy = w_xfer &&  w_winner;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_rsp_vld   = (r_state == S_RESP);
    o_rsp_id    = r_id;
    o_rsp_dst   = r_rsp_dst;
    o_alu_src0  = r_src0;
    o_alu_src1  = r_src1;
    o_alu_op    = r_op;
    o_alu_shamt = r_shamt;
    o_flags0    = w_flags[0];
    o_flags1    = w_flags[1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= RR_INIT;
      r_src0  <= '0;
      r_src1  <= '0;
      r_op    <= '0;
      r_shamt <= '0;
      r_id    <= 1'b0;
    end else if (w_xfer) begin
      r_src0  <= w_src0[w_winner];
      r_src1  <= w_src1[w_winner];
      r_op    <= w_op[w_winner];
      r_shamt <= w_shamt[w_winner];
      r_id    <= w_winner;
      r_ptr   <= ~w_winner;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_dst <= '0;
    end else if (r_state == S_EXEC) begin
      r_rsp_dst <= i_alu_dst;
    end
  end

  // Flag classes: add/sub write all flags, ops 3..7 write only zero, the rest write none.
  always_comb begin
    w_wr_all = (r_op == 4'b0000) || (r_op == 4'b0010);
    w_wr_zr  = !r_op[3] && (r_op[2] || (r_op[1:0] == 2'b11));
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_flags
      logic [2:0] r_flags;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_flags <= 3'b000;
        end else if ((r_state == S_EXEC) && (r_id == 1'(gi))) begin
          if (w_wr_all) begin
            r_flags <= {i_alu_ov, i_alu_zr, i_alu_neg};
          end else if (w_wr_zr) begin
            r_flags[1] <= i_alu_zr;
          end
        end
      end
      assign w_flags[gi] = r_flags;
    end
  endgenerate

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU, cycle-level behavioural model with a
// per-cycle compare loop, directed scenarios with literal expectations, random traffic.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  op0 = '0, sh0 = '0, op1 = '0, sh1 = '0;
  logic        rdy0, rdy1;
  logic [15:0] alu_src0, alu_src1, alu_dst;
  logic [3:0]  alu_op, alu_shamt;
  logic        alu_ov, alu_zr, alu_neg;
  logic        rsp_vld, rsp_id, busy;
  logic [15:0] rsp_dst;
  logic [2:0]  flags0, flags1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rsp_ids [$];
  int rsp_cyc [$];

  always #5 clk = ~clk;

  alu_arbiter #(.W(16), .RR_INIT(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_vld(v0), .i_req0_src0(a0), .i_req0_src1(b0), .i_req0_op(op0), .i_req0_shamt(sh0),
    .o_req0_rdy(rdy0),
    .i_req1_vld(v1), .i_req1_src0(a1), .i_req1_src1(b1), .i_req1_op(op1), .i_req1_shamt(sh1),
    .o_req1_rdy(rdy1),
    .o_alu_src0(alu_src0), .o_alu_src1(alu_src1), .o_alu_op(alu_op), .o_alu_shamt(alu_shamt),
    .i_alu_dst(alu_dst), .i_alu_ov(alu_ov), .i_alu_zr(alu_zr), .i_alu_neg(alu_neg),
    .o_rsp_vld(rsp_vld), .o_rsp_id(rsp_id), .o_rsp_dst(rsp_dst),
    .o_flags0(flags0), .o_flags1(flags1), .o_busy(busy)
  );

  // Reference ALU: returns {ov, zr, neg, dst}
  function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op, input logic [3:0] sh);
    logic [15:0] d;
    logic        ov;
    ov = 1'b0;
    case (op)
      4'd0: begin d = a + b; ov = (a[15] == b[15]) && (d[15] != a[15]); end
      4'd1: d = a + b;
      4'd2: begin d = a - b; ov = (a[15] != b[15]) && (d[15] != a[15]); end
      4'd3: d = a & b;
      4'd4: d = a | b;
      4'd5: d = a << sh;
      4'd6: d = a >> sh;
      4'd7: d = a ^ b;
      default: d = ~a;
    endcase
    return {ov, (d == 16'h0000), d[15], d};
  endfunction

  assign {alu_ov, alu_zr, alu_neg, alu_dst} = alu_fn(alu_src0, alu_src1, alu_op, alu_shamt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stage counts 0 (free), 1 (ALU busy), 2 (answer out)
  int          m_stage;
  bit          m_ptr, m_id;
  logic [15:0] m_s0, m_s1, m_dst;
  logic [3:0]  m_op, m_sh;
  logic [2:0]  m_fl [2];

  task automatic m_reset();
    m_stage = 0; m_ptr = 1'b0; m_id = 1'b0;
    m_s0 = '0; m_s1 = '0; m_op = '0; m_sh = '0; m_dst = '0;
    m_fl[0] = 3'b000; m_fl[1] = 3'b000;
  endtask

  initial begin
    bit          have, win;
    logic [18:0] r;
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      have = (m_stage == 0) && (v0 || v1);
      win  = (v0 && v1) ? m_ptr : v1;
      chk("req0_rdy", 32'(rdy0), 32'(have && !win));
      chk("req1_rdy", 32'(rdy1), 32'(have && win));
      chk("busy", 32'(busy), 32'(m_stage != 0));
      chk("rsp_vld", 32'(rsp_vld), 32'(m_stage == 2));
      if (m_stage == 2) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_dst", 32'(rsp_dst), 32'(m_dst));
      end
      chk("flags0", 32'(flags0), 32'(m_fl[0]));
      chk("flags1", 32'(flags1), 32'(m_fl[1]));
      chk("alu_operands", {alu_src0, alu_src1}, {m_s0, m_s1});
      chk("alu_op_shamt", 32'({alu_op, alu_shamt}), 32'({m_op, m_sh}));
      if (rsp_vld) begin
        rsp_ids.push_back(rsp_id);
        rsp_cyc.push_back(cyc);
      end
      if (!rst) begin
        case (m_stage)
          0: if (have) begin
               m_s0 = win ? a1 : a0;   m_s1 = win ? b1 : b0;
               m_op = win ? op1 : op0; m_sh = win ? sh1 : sh0;
               m_id = win; m_ptr = !win; m_stage = 1;
             end
          1: begin
               r = alu_fn(m_s0, m_s1, m_op, m_sh);
               m_dst = r[15:0];
               if (m_op inside {4'd0, 4'd2}) m_fl[m_id] = r[18:16];
               else if (m_op inside {[4'd3:4'd7]}) m_fl[m_id][1] = r[17];
               m_stage = 2;
             end
          default: m_stage = 0;
        endcase
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [3:0] sh);
    if (n == 0) begin v0 = v; a0 = a; b0 = b; op0 = op; sh0 = sh; end
    else        begin v1 = v; a1 = a; b1 = b; op1 = op; sh1 = sh; end
  endtask

  // Issues one op from requester n; returns at pos+1 of the response cycle.
  task automatic run_op(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [3:0] sh);
    int k;
    set_req(n, 1'b1, a, b, op, sh);
    #1;
    k = 0;
    while (!((n == 0) ? rdy0 : rdy1) && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("grant_wait", 32'(k < 10), 32'd1);
    @(posedge clk);
    #1;
    if (n == 0) v0 = 1'b0; else v1 = 1'b0;
    chk("lit_busy_exec", 32'(busy), 32'd1);
    step();
  endtask

  initial begin
    // Reset and single op from requester 0
    step(); step();
    rst = 1'b0;
    step();
    run_op(0, 16'h0003, 16'hFFFD, 4'b0000, 4'd0);
    chk("lit_single_vld", 32'(rsp_vld), 32'd1);
    chk("lit_single_id", 32'(rsp_id), 32'd0);
    chk("lit_single_dst", 32'(rsp_dst), 32'h0000);
    chk("lit_single_f0", 32'(flags0), 32'b010);
    chk("lit_single_f1", 32'(flags1), 32'b000);
    step();
    chk("lit_single_idle", 32'(busy), 32'd0);

    // Flag retention on requester 1
    run_op(1, 16'hFFFE, 16'h0000, 4'b0000, 4'd0);
    chk("lit_ret_dst", 32'(rsp_dst), 32'hFFFE);
    chk("lit_ret_f1a", 32'(flags1), 32'b001);
    step();
    run_op(1, 16'h0000, 16'($urandom), 4'b0101, 4'd3);
    chk("lit_ret_f1b", 32'(flags1), 32'b011);
    step();
    run_op(1, 16'($urandom), 16'($urandom), 4'b1000, 4'($urandom));
    chk("lit_ret_f1c", 32'(flags1), 32'b011);
    chk("lit_ret_f0", 32'(flags0), 32'b010);
    step();

    // Contention: both valid for 12 cycles
    rsp_ids.delete(); rsp_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      set_req(0, 1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      set_req(1, 1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    step(); step(); step();
    chk("lit_cont_count", 32'(rsp_ids.size()), 32'd4);
    if (rsp_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("lit_cont_id", 32'(rsp_ids[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("lit_cont_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
    end

    // Reset in EXEC of a requester 1 op, both valid
    set_req(1, 1'b1, 16'h1234, 16'h4321, 4'b0010, 4'd0);
    #1;
    chk("lit_rst_grant1", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    v0 = 1'b1; v1 = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_vld", 32'(rsp_vld), 32'd0);
    chk("lit_rst_flags", 32'({flags0, flags1}), 32'd0);
    chk("lit_rst_alu", 32'({alu_src0, alu_src1}), 32'd0);
    chk("lit_rst_rdy", 32'({rdy0, rdy1}), 32'b10);
    step();
    rst = 1'b0;
    #1;
    chk("lit_rel_rdy", 32'({rdy0, rdy1}), 32'b10);
    step();
    v0 = 1'b0; v1 = 1'b0;
    step(); step(); step();

    // Withdrawn request: req0 valid only during RESP of a req1 op
    run_op(1, 16'h00F0, 16'h000F, 4'b0100, 4'd0);
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    rsp_ids.delete();
    step(); step(); step(); step();
    chk("lit_wd_norsp", 32'(rsp_ids.size()), 32'd0);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("lit_wd_ptr", 32'({rdy0, rdy1}), 32'b10);
    step();
    v0 = 1'b0; v1 = 1'b0;
    step(); step();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      set_req(0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
              4'($urandom), 4'($urandom));
      set_req(1, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
              4'($urandom), 4'($urandom));
      step();
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    step(); step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
